uram_port_arbiter: RTL and testbench

Shares one port of the 4K x 72 URAM between two requesters (key-schedule/plaintext loader and SIMON round engine) using round-robin arbitration with valid/ready handshakes. After reset it optionally sequences a zero-fill of the whole memory before accepting traffic. It sits between the cipher datapath and `uram_wrapper` port A; port B stays with other users.

---
 rtl/uram_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uram_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uram_port_arbiter.sv
// Round-robin arbiter sharing one URAM port between two requesters.
// Optionally zero-fills the whole memory after reset before taking traffic.
module uram_port_arbiter #(
    parameter int unsigned DEPTH     = 4096,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_async,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic        req_we_0,
    input  logic        req_we_1,
    input  logic [22:0] req_addr_0,
    input  logic [22:0] req_addr_1,
    input  logic [71:0] req_wdata_0,
    input  logic [71:0] req_wdata_1,
    input  logic [8:0]  req_bwe_0,
    input  logic [8:0]  req_bwe_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    output logic [71:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done,
    output logic        uram_en,
    output logic        uram_we,
    output logic [22:0] uram_addr,
    output logic [71:0] uram_din,
    output logic [8:0]  uram_bwe,
    input  logic [71:0] uram_dout
);

    localparam int AW = 23;

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] FILL_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_RUN
    } state_t;

    state_t        state_q;
    logic [AW-1:0] fill_q;
    logic          rr_q;
    logic          init_done_q;

    logic          en_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [71:0]   din_q;
    logic [8:0]    bwe_q;

    // Stage 1 of the response pipe: command issued to the URAM this cycle.
    logic          s1_vld_q;
    logic          s1_rd_q;
    logic          s1_id_q;
    logic          s1_err_q;

    logic          rsp_v0_q;
    logic          rsp_v1_q;
    logic          rsp_err_q;
    logic          s2_data_q;

    logic          run;
    logic          gnt0;
    logic          gnt1;
    logic          accept;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [71:0]   sel_wdata;
    logic [8:0]    sel_bwe;
    logic          sel_ok;
    logic          fill_last;

    always_comb begin
        run       = (state_q == ST_RUN) && !rst_async;
        gnt0      = run && req_valid_0 && (!req_valid_1 || !rr_q);
        gnt1      = run && req_valid_1 && (!req_valid_0 || rr_q);
        accept    = gnt0 || gnt1;
        sel_we    = gnt1 ? req_we_1    : req_we_0;
        sel_addr  = gnt1 ? req_addr_1  : req_addr_0;
        sel_wdata = gnt1 ? req_wdata_1 : req_wdata_0;
        sel_bwe   = gnt1 ? req_bwe_1   : req_bwe_0;
        sel_ok    = {1'b0, sel_addr} < DEPTH_W;
        fill_last = (fill_q == FILL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst_async) begin
            state_q     <= ST_RESET;
            fill_q      <= '0;
            rr_q        <= 1'b0;
            init_done_q <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            bwe_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_rd_q     <= 1'b0;
            s1_id_q     <= 1'b0;
            s1_err_q    <= 1'b0;
            rsp_v0_q    <= 1'b0;
            rsp_v1_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            s2_data_q   <= 1'b0;
        end else begin
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_rd_q  <= 1'b0;
            s1_id_q  <= 1'b0;
            s1_err_q <= 1'b0;
            unique case (state_q)
                ST_RESET: begin
                    fill_q      <= '0;
                    state_q     <= INIT_ZERO ? ST_INIT : ST_RUN;
                    init_done_q <= !INIT_ZERO;
                end
                ST_INIT: begin
                    en_q   <= 1'b1;
                    we_q   <= 1'b1;
                    addr_q <= fill_q;
                    din_q  <= '0;
                    bwe_q  <= '1;
                    if (fill_last) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        fill_q <= fill_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        rr_q     <= gnt0;
                        s1_vld_q <= 1'b1;
                        s1_rd_q  <= !sel_we;
                        s1_id_q  <= gnt1;
                        s1_err_q <= !sel_ok;
                        // Out-of-range commands are tracked but never touch memory.
                        if (sel_ok) begin
                            en_q   <= 1'b1;
                            we_q   <= sel_we;
                            addr_q <= sel_addr;
                            din_q  <= sel_wdata;
                            bwe_q  <= sel_we ? sel_bwe : 9'h000;
                        end
                    end
                end
                default: state_q <= ST_RESET;
            endcase
            rsp_v0_q  <= s1_vld_q && s1_rd_q && !s1_id_q;
            rsp_v1_q  <= s1_vld_q && s1_rd_q && s1_id_q;
            rsp_err_q <= s1_vld_q && s1_err_q;
            s2_data_q <= s1_vld_q && s1_rd_q && !s1_err_q;
        end
    end

    assign req_ready_0 = gnt0;
    assign req_ready_1 = gnt1;
    assign rsp_valid_0 = rsp_v0_q;
    assign rsp_valid_1 = rsp_v1_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = s2_data_q ? uram_dout : 72'h0;
    assign init_done   = init_done_q;
    assign uram_en     = en_q;
    assign uram_we     = we_q;
    assign uram_addr   = addr_q;
    assign uram_din    = din_q;
    assign uram_bwe    = bwe_q;

endmodule

// File: tb/tb_uram_port_arbiter.sv
// Directed bench for uram_port_arbiter with a behavioural URAM port model.
module tb_uram_port_arbiter;

    localparam int DEPTH = 4096;

    logic        clk;
    logic        rst_async;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic        req_we_0, req_we_1;
    logic [22:0] req_addr_0, req_addr_1;
    logic [71:0] req_wdata_0, req_wdata_1;
    logic [8:0]  req_bwe_0, req_bwe_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic [71:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;
    logic        uram_en, uram_we;
    logic [22:0] uram_addr;
    logic [71:0] uram_din;
    logic [8:0]  uram_bwe;
    logic [71:0] uram_dout;

    int n_chk  = 0;
    int n_fail = 0;

    int fill_mon = 0;
    int fill_cnt = 0;
    int fill_bad = 0;

    logic [71:0] mem [DEPTH];

    localparam logic [71:0] PAT_A5 = {9{8'hA5}};
    localparam logic [71:0] PAT_BE = {{8{8'hFF}}, 8'h00};

    uram_port_arbiter #(.DEPTH(DEPTH), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .rst_async(rst_async),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_we_0(req_we_0), .req_we_1(req_we_1),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
        .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
        .req_bwe_0(req_bwe_0), .req_bwe_1(req_bwe_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .init_done(init_done),
        .uram_en(uram_en), .uram_we(uram_we),
        .uram_addr(uram_addr), .uram_din(uram_din),
        .uram_bwe(uram_bwe), .uram_dout(uram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {9{8'h5A}};
        uram_dout = 72'h0;
    end

    always @(posedge clk) begin
        if (uram_en) begin
            if (uram_we) begin
                for (int b = 0; b < 9; b++)
                    if (uram_bwe[b])
                        mem[uram_addr[11:0]][b*8 +: 8] <= uram_din[b*8 +: 8];
            end else begin
                uram_dout <= mem[uram_addr[11:0]];
            end
        end
    end

    always @(negedge clk) begin
        if (fill_mon != 0) begin
            if (uram_en) begin
                if (!(uram_we && uram_addr == 23'(fill_cnt) &&
                      uram_din == 72'h0 && uram_bwe == 9'h1FF))
                    fill_bad++;
                fill_cnt++;
            end
            if (!init_done && (req_ready_0 || req_ready_1))
                fill_bad++;
        end
    end

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid_0 = 0; req_valid_1 = 0;
        req_we_0 = 0; req_we_1 = 0;
        req_addr_0 = '0; req_addr_1 = '0;
        req_wdata_0 = '0; req_wdata_1 = '0;
        req_bwe_0 = '0; req_bwe_1 = '0;
    endtask

    task automatic drive(input int k, input logic we, input logic [22:0] a,
                         input logic [71:0] d, input logic [8:0] be);
        if (k == 0) begin
            req_valid_0 = 1; req_we_0 = we; req_addr_0 = a;
            req_wdata_0 = d; req_bwe_0 = be;
        end else begin
            req_valid_1 = 1; req_we_1 = we; req_addr_1 = a;
            req_wdata_1 = d; req_bwe_1 = be;
        end
    endtask

    task automatic wr(input int k, input logic [22:0] a,
                      input logic [71:0] d, input logic [8:0] be);
        drive(k, 1'b1, a, d, be);
        @(negedge clk);
        check("wr_ready", k == 0 ? req_ready_0 : req_ready_1, 1);
        step;
        req_valid_0 = 0; req_valid_1 = 0;
    endtask

    task automatic rd(input int k, input logic [22:0] a, input logic exp_en,
                      input logic exp_err, input logic [71:0] exp_d);
        drive(k, 1'b0, a, 72'h0, 9'h0);
        @(negedge clk);
        check("rd_ready", k == 0 ? req_ready_0 : req_ready_1, 1);
        step;
        req_valid_0 = 0; req_valid_1 = 0;
        @(negedge clk);
        check("rd_en", uram_en, exp_en);
        step;
        @(negedge clk);
        check("rd_vld", k == 0 ? rsp_valid_0 : rsp_valid_1, 1);
        check("rd_vld_other", k == 0 ? rsp_valid_1 : rsp_valid_0, 0);
        check("rd_data", rsp_rdata, exp_d);
        check("rd_err", rsp_err, exp_err);
    endtask

    task automatic reset_and_fill;
        int n;
        rst_async = 1;
        drive(0, 1'b0, 23'h0, 72'h0, 9'h0);
        step;
        step;
        @(negedge clk);
        check("rst_ready0", req_ready_0, 0);
        check("rst_en", uram_en, 0);
        check("rst_we", uram_we, 0);
        check("rst_addr", uram_addr, 0);
        check("rst_din", uram_din, 0);
        check("rst_bwe", uram_bwe, 0);
        check("rst_rsp", {rsp_valid_1, rsp_valid_0, rsp_err}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_done", init_done, 0);
        step;
        rst_async = 0;
        fill_cnt = 0;
        fill_bad = 0;
        fill_mon = 1;
        n = 0;
        while (!init_done && n < DEPTH + 20) begin
            step;
            n++;
        end
        req_valid_0 = 0;
        @(negedge clk);
        #1;
        fill_mon = 0;
        check("fill_cycles", n, DEPTH + 1);
        check("fill_writes", fill_cnt, DEPTH);
        check("fill_bad", fill_bad, 0);
        step;
    endtask

    initial begin
        idle_inputs();
        rst_async = 1;

        reset_and_fill();
        rd(0, 23'hFFF, 1, 0, 72'h0);
        step;

        // Write then read the same address in consecutive cycles.
        drive(0, 1'b1, 23'h010, PAT_A5, 9'h1FF);
        @(negedge clk);
        check("w_ready0", req_ready_0, 1);
        step;
        drive(0, 1'b0, 23'h010, 72'h0, 9'h1FF);
        @(negedge clk);
        check("w_en", {uram_en, uram_we}, 2'b11);
        check("w_addr", uram_addr, 23'h010);
        check("w_din", uram_din, PAT_A5);
        check("w_bwe", uram_bwe, 9'h1FF);
        check("r_ready0", req_ready_0, 1);
        step;
        req_valid_0 = 0;
        @(negedge clk);
        check("r_en", {uram_en, uram_we}, 2'b10);
        check("r_bwe", uram_bwe, 9'h000);
        check("r_early", rsp_valid_0, 0);
        step;
        @(negedge clk);
        check("r_vld0", rsp_valid_0, 1);
        check("r_vld1", rsp_valid_1, 0);
        check("r_data", rsp_rdata, PAT_A5);
        check("r_err", rsp_err, 0);
        step;

        wr(1, 23'h020, {9{8'hFF}}, 9'h1FF);
        wr(1, 23'h020, 72'h0, 9'h001);
        rd(1, 23'h020, 1, 0, PAT_BE);
        step;

        // Both requesters valid for 8 cycles; pointer starts at requester 0.
        for (int i = 0; i < 10; i++) begin
            req_valid_0 = (i < 8); req_we_0 = 0; req_addr_0 = 23'h010;
            req_valid_1 = (i < 8); req_we_1 = 0; req_addr_1 = 23'h020;
            @(negedge clk);
            if (i < 8) begin
                check("cont_rdy0", req_ready_0, (i % 2) == 0);
                check("cont_rdy1", req_ready_1, (i % 2) == 1);
            end
            if (i >= 1 && i <= 8) begin
                check("cont_en", uram_en, 1);
                check("cont_addr", uram_addr,
                      ((i - 1) % 2) == 0 ? 23'h010 : 23'h020);
            end
            if (i >= 2) begin
                check("cont_vld0", rsp_valid_0, ((i - 2) % 2) == 0);
                check("cont_vld1", rsp_valid_1, ((i - 2) % 2) == 1);
                check("cont_data", rsp_rdata,
                      ((i - 2) % 2) == 0 ? PAT_A5 : PAT_BE);
            end
            step;
        end
        idle_inputs();

        rd(1, 23'h1000, 0, 1, 72'h0);
        step;

        drive(0, 1'b1, 23'h7FFFFF, PAT_A5, 9'h1FF);
        @(negedge clk);
        check("oor_w_ready", req_ready_0, 1);
        step;
        req_valid_0 = 0;
        @(negedge clk);
        check("oor_w_en", uram_en, 0);
        step;
        @(negedge clk);
        check("oor_w_err", rsp_err, 1);
        step;

        // Reset lands the cycle after a read accept.
        drive(0, 1'b0, 23'h010, 72'h0, 9'h0);
        @(negedge clk);
        check("mid_ready", req_ready_0, 1);
        step;
        req_valid_0 = 0;
        rst_async = 1;
        step;
        @(negedge clk);
        check("mid_vld", {rsp_valid_1, rsp_valid_0}, 0);
        check("mid_en", uram_en, 0);
        check("mid_done", init_done, 0);
        step;
        @(negedge clk);
        check("mid_vld2", {rsp_valid_1, rsp_valid_0}, 0);

        reset_and_fill();
        rd(0, 23'h010, 1, 0, 72'h0);
        step;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
